// File: rtl/spi_pkg.sv
// Shared encodings for the SPI transfer engine: FSM state codes, mode bit indices and widths.
package spi_pkg;

    localparam int NUM_CS   = 4;
    localparam int DATA_W   = 32;
    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'hA,
        ST_CS_SETUP = 4'hB,
        ST_SHIFT    = 4'hC,
        ST_CS_HOLD  = 4'hD
    } spi_state_t;

    // Picks the {CPOL,CPHA} pair that belongs to one chip select.
    function automatic logic [1:0] mode_of(input logic [7:0] modes, input logic [1:0] cs);
        logic [1:0] m;
        case (cs)
            2'd0:    m = modes[1:0];
            2'd1:    m = modes[3:2];
            2'd2:    m = modes[5:4];
            default: m = modes[7:6];
        endcase
        return m;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period tick generator: one-cycle tick every max(brd,1) clk cycles, restartable.
module spi_half_tick (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] brd,
    input  logic        restart,
    output logic        tick
);

    logic [31:0] cnt;
    logic [31:0] reload;

    // brd of 0 behaves as 1, i.e. a tick on every cycle.
    assign reload = (brd == 32'd0) ? 32'd0 : brd - 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 32'd0;
        end else if (restart || cnt == 32'd0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - 32'd1;
        end
    end

    assign tick = !restart && (cnt == 32'd0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// SPI transfer engine: TX FIFO pop, chip-select control, SCLK modes 0-3, MSB-first shifting, RX push.
// Optional back-to-back bursts with CS held low are enabled by defining SPI_CS_BURST_EN.
module spi_xfer_sequencer
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [4:0]        word_size,
    input  logic [1:0]        cs_select,
    input  logic [3:0]        cs_auto,
    input  logic [3:0]        cs_enable,
    input  logic [7:0]        modes,
    input  logic [31:0]       brd,
    input  logic              tx_empty,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_pop,
    input  logic              rx_full,
    output logic              rx_push,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_overflow,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_tx,
    input  logic              spi_rx,
    output logic [3:0]        spi_cs,
    output logic [3:0]        state_dbg
);

    spi_state_t        state, state_next;
    logic [4:0]        ws_q;
    logic [1:0]        cs_q, cs_q_next;
    logic              cpol_q, cpha_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_word;
    logic [6:0]        edge_cnt, edge_idx, edge_total;
    logic              sclk;
    logic [3:0]        cs_r, cs_next;
    logic              rx_s1, rx_s2, sample_d1;
    logic              tick, last_edge, edge_odd, shift_evt, sample_evt;
    logic              in_shift_tick, hold_done, load;
    logic [1:0]        mode_live;
    logic              cpol_live;

    spi_half_tick u_half_tick (
        .clk     (clk),
        .reset   (reset),
        .brd     (brd),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    assign mode_live  = mode_of(modes, cs_select);
    assign cpol_live  = mode_live[CPOL_BIT];

    // Edges are numbered 1..2*(ws+1); odd edges are leading, even edges trailing.
    assign edge_idx   = edge_cnt + 7'd1;
    assign edge_total = {1'b0, ws_q, 1'b0} + 7'd2;
    assign last_edge  = (edge_idx == edge_total);
    assign edge_odd   = edge_idx[0];
    assign shift_evt  = cpha_q ? (edge_odd && edge_idx != 7'd1) : !edge_odd;
    assign sample_evt = cpha_q ? !edge_odd : edge_odd;
    assign in_shift_tick = (state == ST_SHIFT) && tick && enable;

    // FIFO handshakes: a TX word transfers on any cycle with !tx_empty && tx_pop; an RX word
    // transfers on rx_push, which is only raised when !rx_full (otherwise rx_overflow pulses).
    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        hold_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && !tx_empty) begin
                    tx_pop     = 1'b1;
                    state_next = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (!enable)   state_next = ST_IDLE;
                else if (tick) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!enable)                state_next = ST_IDLE;
                else if (tick && last_edge) state_next = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    hold_done  = 1'b1;
                    state_next = ST_IDLE;
`ifdef SPI_CS_BURST_EN
                    if (!tx_empty && cs_select == cs_q && cs_auto[cs_q]) begin
                        tx_pop     = 1'b1;
                        state_next = ST_SHIFT;
                    end
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign load      = tx_pop;
    assign cs_q_next = (load && state == ST_IDLE) ? cs_select : cs_q;

    // CS lines are registered from the next state so they move exactly with the FSM.
    always_comb begin
        cs_next = 4'hF;
        for (int n = 0; n < NUM_CS; n++) begin
            if (cs_auto[n]) cs_next[n] = !(state_next != ST_IDLE && cs_q_next == 2'(n));
            else            cs_next[n] = !cs_enable[n];
        end
    end

    // The final sample can still be in flight on the push cycle, so it is forwarded here.
    assign rx_word = sample_d1 ? {rx_sr[DATA_W-2:0], rx_s2} : rx_sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ws_q      <= 5'd0;
            cs_q      <= 2'd0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            edge_cnt  <= 7'd0;
            sclk      <= 1'b0;
            cs_r      <= 4'hF;
            rx_s1     <= 1'b0;
            rx_s2     <= 1'b0;
            sample_d1 <= 1'b0;
        end else begin
            state     <= state_next;
            cs_r      <= cs_next;
            rx_s1     <= spi_rx;
            rx_s2     <= rx_s1;
            sample_d1 <= in_shift_tick && sample_evt;
            if (load) begin
                ws_q     <= word_size;
                tx_sr    <= tx_data << (5'd31 - word_size);
                edge_cnt <= 7'd0;
                rx_sr    <= '0;
                if (state == ST_IDLE) begin
                    cs_q   <= cs_select;
                    cpol_q <= mode_live[CPOL_BIT];
                    cpha_q <= mode_live[CPHA_BIT];
                end
            end else begin
                if (in_shift_tick) begin
                    edge_cnt <= edge_idx;
                    if (shift_evt) tx_sr <= tx_sr << 1;
                end
                if (sample_d1) rx_sr <= rx_word;
            end
            if (state_next == ST_IDLE || state == ST_IDLE) sclk <= cpol_live;
            else if (in_shift_tick)                          sclk <= ~sclk;
        end
    end

    assign rx_data     = rx_word;
    assign rx_push     = hold_done && !rx_full;
    assign rx_overflow = hold_done && rx_full;
    assign busy        = (state != ST_IDLE);
    assign spi_clk     = sclk;
    assign spi_tx      = (state != ST_IDLE) && tx_sr[DATA_W-1];
    assign spi_cs      = cs_r;
    assign state_dbg   = state;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer: loopback scoreboard on RX words, MOSI/SCLK/CS monitors.
module tb_spi_xfer_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        enable, tx_empty, tx_pop, rx_full, rx_push, rx_overflow, busy;
    logic        spi_clk, spi_tx, spi_rx;
    logic [4:0]  word_size;
    logic [1:0]  cs_select;
    logic [3:0]  cs_auto, cs_enable, spi_cs, state_dbg;
    logic [7:0]  modes;
    logic [31:0] brd, tx_data, rx_data;
    logic        miso_force, miso_val;

    spi_xfer_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .word_size   (word_size),
        .cs_select   (cs_select),
        .cs_auto     (cs_auto),
        .cs_enable   (cs_enable),
        .modes       (modes),
        .brd         (brd),
        .tx_empty    (tx_empty),
        .tx_data     (tx_data),
        .tx_pop      (tx_pop),
        .rx_full     (rx_full),
        .rx_push     (rx_push),
        .rx_data     (rx_data),
        .rx_overflow (rx_overflow),
        .busy        (busy),
        .spi_clk     (spi_clk),
        .spi_tx      (spi_tx),
        .spi_rx      (spi_rx),
        .spi_cs      (spi_cs),
        .state_dbg   (state_dbg)
    );

    assign spi_rx = miso_force ? miso_val : spi_tx;

    // ---------------- TX FIFO model (first-word fall-through) ----------------
    logic [31:0] tx_mem [0:15];
    int tx_cnt = 0;
    int tx_idx = 0;
    always @(posedge clk) if (tx_pop) tx_idx <= tx_idx + 1;
    always @* begin
        tx_empty = (tx_idx >= tx_cnt);
        tx_data  = (tx_idx < 16) ? tx_mem[tx_idx] : 32'd0;
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int push_cnt = 0, ovf_cnt = 0, edge_n = 0, cs0_low = 0, cs0_rise = 0, cs_bad = 0;
    logic [31:0] mosi_sr = 32'd0;
    logic cur_cpol = 1'b0, cur_cpha = 1'b0, manual_chk = 1'b0;
    logic [3:0] manual_exp = 4'hF;

    always @(negedge clk) begin
        if (rx_push) begin
            push_cnt++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL rx_unexpected: observed=0x%08h expected=no push", rx_data);
            end
            if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        end
        if (rx_overflow) ovf_cnt++;
        if (!spi_cs[0]) cs0_low++;
        if (manual_chk && spi_cs !== manual_exp) cs_bad++;
    end

    always @(posedge spi_cs[0]) cs0_rise++;

    // Capture MOSI on the edge the slave samples on: leading for CPHA=0, trailing for CPHA=1.
    always @(spi_clk) begin
        if (busy) begin
            edge_n++;
            if ((spi_clk != cur_cpol) ^ cur_cpha) mosi_sr = {mosi_sr[30:0], spi_tx};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [31:0] w, input logic expect_rx, input logic [31:0] exp);
        tx_mem[tx_cnt] = w;
        tx_cnt++;
        if (expect_rx) exp_q.push_back(exp);
    endtask

    task automatic wait_ends(input int n, input int budget, input string tag);
        int base = push_cnt + ovf_cnt;
        int c = 0;
        while ((push_cnt + ovf_cnt - base) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        check(tag, 32'(c < budget), 32'd1);
    endtask

    task automatic wait_edges(input int n, input int budget, input string tag);
        int base = edge_n;
        int c = 0;
        while ((edge_n - base) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(c < budget), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    int e0, c0, p0, o0, r0, b0;
    logic [31:0] w;
    logic [1:0]  mm;

    initial begin
        for (int i = 0; i < 16; i++) tx_mem[i] = 32'd0;
        reset = 1'b1; enable = 1'b0; word_size = 5'd7; cs_select = 2'd0;
        cs_auto = 4'hF; cs_enable = 4'h0; modes = 8'h00; brd = 32'd2;
        rx_full = 1'b0; miso_force = 1'b0; miso_val = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_spi_cs", 32'(spi_cs), 32'hF);
        check("rst_spi_clk", 32'(spi_clk), 32'd0);
        check("rst_spi_tx", 32'(spi_tx), 32'd0);
        check("rst_tx_pop", 32'(tx_pop), 32'd0);
        check("rst_rx_push", 32'(rx_push), 32'd0);
        check("rst_rx_ovf", 32'(rx_overflow), 32'd0);
        check("rst_rx_data", rx_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(state_dbg), 32'hA);
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        // Mode 0, 8-bit 0xA5 loopback.
        e0 = edge_n; c0 = cs0_low; p0 = push_cnt;
        send_word(32'hA5, 1'b1, 32'hA5);
        wait_ends(1, 200, "t1_timeout");
        check("t1_mosi", {24'd0, mosi_sr[7:0]}, 32'hA5);
        check("t1_edges", 32'(edge_n - e0), 32'd16);
        check("t1_cs0_low", 32'(cs0_low - c0), 32'd36);
        check("t1_push", 32'(push_cnt - p0), 32'd1);
        check("t1_state", 32'(state_dbg), 32'hA);
        check("t1_cs_idle", 32'(spi_cs), 32'hF);

        // Modes 1..3, 16-bit 0x1234 loopback.
        word_size = 5'd15;
        for (int m = 1; m < 4; m++) begin
            mm = 2'(m);
            modes = {6'd0, mm};
            cur_cpol = mm[1]; cur_cpha = mm[0];
            repeat (2) @(negedge clk);
            check("mode_idle_clk", 32'(spi_clk), 32'(mm[1]));
            e0 = edge_n;
            send_word(32'h1234, 1'b1, 32'h1234);
            wait_ends(1, 300, "mode_timeout");
            check("mode_mosi", {16'd0, mosi_sr[15:0]}, 32'h1234);
            check("mode_edges", 32'(edge_n - e0), 32'd32);
            check("mode_end_clk", 32'(spi_clk), 32'(mm[1]));
        end

        // Idle clock level follows the currently selected CS.
        modes = 8'b10_00_00_00; cs_select = 2'd3;
        repeat (2) @(negedge clk);
        check("idle_clk_cs3", 32'(spi_clk), 32'd1);
        cs_select = 2'd0;
        repeat (2) @(negedge clk);
        check("idle_clk_cs0", 32'(spi_clk), 32'd0);
        modes = 8'h00; cur_cpol = 1'b0; cur_cpha = 1'b0;

        // Manual CS2 held low through three words.
        word_size = 5'd7; cs_auto = 4'b1011; cs_enable = 4'b0100; cs_select = 2'd2;
        repeat (2) @(negedge clk);
        check("man_idle_cs", 32'(spi_cs), 32'hB);
        manual_exp = 4'b1011; manual_chk = 1'b1; b0 = cs_bad; p0 = push_cnt;
        for (int k = 0; k < 3; k++) begin
            w = 32'($urandom_range(0, 255));
            send_word(w, 1'b1, w);
        end
        wait_ends(3, 600, "man_timeout");
        check("man_cs_stable", 32'(cs_bad - b0), 32'd0);
        check("man_push", 32'(push_cnt - p0), 32'd3);
        manual_chk = 1'b0;
        check("man_end_cs", 32'(spi_cs), 32'hB);
        cs_auto = 4'hF; cs_enable = 4'h0; cs_select = 2'd0;

        // RX full at end of word: overflow instead of push.
        rx_full = 1'b1; p0 = push_cnt; o0 = ovf_cnt;
        send_word(32'h3C, 1'b0, 32'd0);
        wait_ends(1, 200, "ovf_timeout");
        check("ovf_no_push", 32'(push_cnt - p0), 32'd0);
        check("ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
        check("ovf_state", 32'(state_dbg), 32'hA);
        rx_full = 1'b0;

        // Enable dropped mid-SHIFT.
        p0 = push_cnt; o0 = ovf_cnt;
        send_word(32'hFF, 1'b0, 32'd0);
        wait_edges(5, 200, "abort_timeout");
        enable = 1'b0;
        @(negedge clk);
        check("abort_state", 32'(state_dbg), 32'hA);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cs0", 32'(spi_cs[0]), 32'd1);
        check("abort_clk", 32'(spi_clk), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_no_push", 32'(push_cnt - p0 + ovf_cnt - o0), 32'd0);
        enable = 1'b1;

        // Asynchronous reset mid-transfer.
        send_word(32'h5A, 1'b0, 32'd0);
        wait_edges(3, 200, "arst_timeout");
        #2 reset = 1'b1;
        #1;
        check("arst_cs", 32'(spi_cs), 32'hF);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_tx", 32'(spi_tx), 32'd0);
        check("arst_rx_data", rx_data, 32'd0);
        check("arst_state", 32'(state_dbg), 32'hA);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // brd=0: one-clk half-period, full 32-bit word, MISO held high.
        brd = 32'd0; word_size = 5'd31; miso_force = 1'b1; miso_val = 1'b1;
        repeat (3) @(negedge clk);
        w = $urandom;
        e0 = edge_n; c0 = cs0_low;
        send_word(w, 1'b1, 32'hFFFF_FFFF);
        wait_ends(1, 300, "b0_timeout");
        check("b0_mosi", mosi_sr, w);
        check("b0_edges", 32'(edge_n - e0), 32'd64);
        check("b0_cs0_low", 32'(cs0_low - c0), 32'd66);
        miso_force = 1'b0;

        // Two queued words back to back.
        brd = 32'd2; word_size = 5'd7;
        repeat (3) @(negedge clk);
        r0 = cs0_rise; c0 = cs0_low; p0 = push_cnt;
        for (int k = 0; k < 2; k++) begin
            w = 32'($urandom_range(0, 255));
            send_word(w, 1'b1, w);
        end
        wait_ends(2, 400, "pair_timeout");
        check("pair_push", 32'(push_cnt - p0), 32'd2);
`ifdef SPI_CS_BURST_EN
        check("pair_cs_rise", 32'(cs0_rise - r0), 32'd1);
        check("pair_cs0_low", 32'(cs0_low - c0), 32'd70);
`else
        check("pair_cs_rise", 32'(cs0_rise - r0), 32'd2);
        check("pair_cs0_low", 32'(cs0_low - c0), 32'd72);
`endif

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
